// File: rtl/tlv5638_spi_rx.sv
// SPI slave receiver for TLV5638-format 16-bit command frames. Oversamples CS_N/SCLK/DIN on
// clk_20M, shifts on SCLK falling edges and decodes each complete frame into DAC/control state.
module tlv5638_spi_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 16
) (
  input  logic        clk_20M,
  input  logic        rst_n,
  input  logic        CS_N,
  input  logic        SCLK,
  input  logic        DIN,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic [11:0] buf_reg,
  output logic [1:0]  ref_sel,
  output logic        speed,
  output logic        pwr_down,
  output logic [15:0] rx_word,
  output logic        frame_valid,
  output logic        frame_err
);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  localparam logic [4:0] FrameCnt = 5'(FRAME_BITS);
  localparam logic [4:0] MaxCnt   = 5'(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, din_sync_q;
  logic                   cs_s, sclk_s, din_s;
  logic                   cs_prev_q, sclk_prev_q, din_prev_q;
  logic                   sclk_fall_q, cs_fall_q, cs_rise_q;
  logic [SYNC_STAGES:0]   flush_q;
  logic                   armed_q, armed_d;
  logic                   cs_pend_q, cs_pend_d;

  state_e                 state_q, state_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;

  logic [11:0] dac_a_q, dac_a_d, dac_b_q, dac_b_d, buf_q, buf_d;
  logic [1:0]  ref_sel_q, ref_sel_d;
  logic        speed_q, speed_d, pwr_q, pwr_d;
  logic [15:0] rx_word_q, rx_word_d;
  logic        frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];

  // A CS_N fall only counts once a genuine high level has passed through the synchronizer after
  // reset, so releasing reset with CS_N already low cannot start a frame.
  assign armed_d = armed_q | (flush_q[SYNC_STAGES] & cs_prev_q);

  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      din_sync_q  <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      din_prev_q  <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_N};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], DIN};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      // DIN is delayed alongside the strobe so it is sampled as of the SCLK fall.
      din_prev_q  <= din_s;
      sclk_fall_q <= sclk_prev_q & ~sclk_s;
      cs_fall_q   <= armed_d & cs_prev_q & ~cs_s;
      cs_rise_q   <= ~cs_prev_q & cs_s;
      flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      armed_q     <= armed_d;
    end
  end

  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      cs_pend_q     <= 1'b0;
      dac_a_q       <= '0;
      dac_b_q       <= '0;
      buf_q         <= '0;
      ref_sel_q     <= '0;
      speed_q       <= 1'b0;
      pwr_q         <= 1'b0;
      rx_word_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      cs_pend_q     <= cs_pend_d;
      dac_a_q       <= dac_a_d;
      dac_b_q       <= dac_b_d;
      buf_q         <= buf_d;
      ref_sel_q     <= ref_sel_d;
      speed_q       <= speed_d;
      pwr_q         <= pwr_d;
      rx_word_q     <= rx_word_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    cs_pend_d     = cs_pend_q;
    dac_a_d       = dac_a_q;
    dac_b_d       = dac_b_q;
    buf_d         = buf_q;
    ref_sel_d     = ref_sel_q;
    speed_d       = speed_q;
    pwr_d         = pwr_q;
    rx_word_d     = rx_word_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall_q || cs_pend_q) begin
          state_d   = StShift;
          bit_cnt_d = '0;
          shift_d   = '0;
          cs_pend_d = 1'b0;
        end
      end
      StShift: begin
        if (sclk_fall_q && !cs_prev_q) begin
          shift_d = {shift_q[FRAME_BITS-2:0], din_prev_q};
          if (bit_cnt_q != MaxCnt) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        if (cs_rise_q) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        state_d   = StIdle;
        // A new frame start landing here is held over for the next idle cycle.
        cs_pend_d = cs_fall_q;
        if (bit_cnt_q == FrameCnt) begin
          frame_valid_d = 1'b1;
          rx_word_d     = shift_q[15:0];
          unique case ({shift_q[15], shift_q[12]})
            2'b00: begin
              dac_b_d = shift_q[11:0];
              buf_d   = shift_q[11:0];
              speed_d = shift_q[14];
              pwr_d   = shift_q[13];
            end
            2'b01: begin
              buf_d   = shift_q[11:0];
              speed_d = shift_q[14];
              pwr_d   = shift_q[13];
            end
            2'b10: begin
              dac_a_d = shift_q[11:0];
              dac_b_d = buf_q;
              speed_d = shift_q[14];
              pwr_d   = shift_q[13];
            end
            default: ref_sel_d = shift_q[1:0];
          endcase
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign dac_a       = dac_a_q;
  assign dac_b       = dac_b_q;
  assign buf_reg     = buf_q;
  assign ref_sel     = ref_sel_q;
  assign speed       = speed_q;
  assign pwr_down    = pwr_q;
  assign rx_word     = rx_word_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: doc/tlv5638_spi_rx.md
Name: tlv5638_spi_rx

Overview:
- SPI slave that receives 16-bit TLV5638-format command frames on CS_N/SCLK/DIN, decodes them and holds the resulting DAC A/B, buffer and control state.
- Used as a loopback checker and emulator for DAC write paths and external SPI masters. It sits on the clk_20M fabric domain.
- All SPI inputs are oversampled through synchronizers. The block itself generates no clock.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer chain (legal range 2..3).
- FRAME_BITS, 16, number of bits in a valid frame (fixed at 16 for the TLV5638 format).

Ports:
- clk_20M  input  1  system clock, 20 MHz.
- rst_n  input  1  reset; asynchronous, active-low.
- CS_N  input  1  SPI chip select, active-low, asynchronous to clk_20M.
- SCLK  input  1  SPI clock, asynchronous; at most clk_20M/4 (5 MHz).
- DIN  input  1  SPI data, MSB first, latched on the SCLK falling edge.
- dac_a  output  12  DAC A output code.
- dac_b  output  12  DAC B output code.
- buf_reg  output  12  double-buffer latch.
- ref_sel  output  2  reference select (REF1:REF0).
- speed  output  1  SPD bit from the last DAC-data frame.
- pwr_down  output  1  PWR bit from the last DAC-data frame.
- rx_word  output  16  last complete 16-bit frame received.
- frame_valid  output  1  one-cycle pulse when a complete frame is committed.
- frame_err  output  1  one-cycle pulse when a frame ends with a bit count other than 16.

Behaviour:
- Reset: all outputs and internal registers are 0. This includes synchronizer flops, except that CS_N synchronizer flops reset to 1 so no false frame start occurs.
- Synchronization: CS_N, SCLK and DIN each pass through SYNC_STAGES flops. A further edge-detect register per signal gives sclk_fall, cs_fall and cs_rise strobes.
- DIN sampling: the synchronized DIN has the same delay as the synchronized SCLK. It is sampled on the cycle sclk_fall is true.
- States:
  - IDLE: on cs_fall, clear bit_cnt (5 bits) and shift register, then go to SHIFT.
  - SHIFT: on each sclk_fall while synchronized CS_N=0, do shift_reg <= {shift_reg[14:0], din_s}. bit_cnt increments and saturates at 17. On cs_rise, go to COMMIT.
  - COMMIT (one cycle): if bit_cnt==16, decode and pulse frame_valid; otherwise pulse frame_err and update nothing. Then go to IDLE.
- SCLK edges while CS_N is high are ignored.
- Decode of word w (R1=w[15], SPD=w[14], PWR=w[13], R0=w[12], D=w[11:0]):
  - R1R0=00: dac_b<=D, buf_reg<=D, speed<=SPD, pwr_down<=PWR.
  - R1R0=01: buf_reg<=D, speed<=SPD, pwr_down<=PWR.
  - R1R0=10: dac_a<=D, dac_b<=buf_reg (the value before this frame), speed<=SPD, pwr_down<=PWR.
  - R1R0=11: ref_sel<=D[1:0]; speed and pwr_down are unchanged.
  - rx_word<=w on every valid frame.
- Commit timing: decoded outputs, rx_word and frame_valid all update on the same clock edge, which is the edge that ends COMMIT.
- Latency: frame_valid rises SYNC_STAGES+2 clk_20M edges after the first clock edge that samples CS_N high. With the default, that is 4 edges.
- Boundary conditions:
  - More than 16 falling edges: frame_err; outputs keep their previous values.
  - Fewer than 16 falling edges, including 0: frame_err.
  - A CS_N glitch shorter than one clk_20M period may be missed. That is allowed; no partial update may result from it.
  - cs_fall in the same cycle as COMMIT: the COMMIT completes, and the block returns to IDLE and accepts the new frame start. The CS_N fall must be detected and cannot be lost, so a cs_fall seen during COMMIT is registered and acted on in IDLE.
  - rst_n asserted mid-frame: everything clears immediately. Once rst_n releases with CS_N low, no frame starts until a fresh CS_N fall.
  - frame_valid and frame_err are never asserted together.

Test Plan:
- Send frame 0x1ABC (R1R0=01) at SCLK=2 MHz, then 0x8123 (R1R0=10) -> buf_reg=0xABC after the first frame. After the second: dac_a=0x123, dac_b=0xABC, frame_valid pulses twice, rx_word=0x8123.
- Send frame 0x4555 (R1R0=00, SPD=1) -> dac_b=0x555, buf_reg=0x555, speed=1, pwr_down=0. frame_valid occurs exactly 4 clk_20M edges after CS_N is sampled high.
- Send frame 0x9003 (R1R0=11) after 0x6FFF -> ref_sel=2'b11, speed=1, pwr_down=1 unchanged, dac_a unchanged.
- Send a 15-bit frame, then a 17-bit frame -> frame_err pulses once for each, and all outputs keep their prior values.
- Toggle SCLK 10 times with CS_N high, then send a valid 0x0123 -> only the valid frame is decoded: dac_b=0x123.
- Assert rst_n low after 8 bits of 0x8FFF, release it, then send 0x0001 -> all outputs are 0 after reset, then dac_b=0x001, and no frame_err.
